// File: rtl/getir_tamponu.sv
// Fetch front-end: one outstanding I-cache request at a time, returned {pc, instr}
// pairs queued in a DERINLIK-deep FIFO, registered output stage towards decode.
module getir_tamponu #(
    parameter int              DERINLIK     = 4,
    parameter int              AW           = 32,
    parameter int              BW           = 32,
    parameter int              YON_SAYISI   = 3,
    parameter logic [AW-1:0]   BASLANGIC_PS = '0,
    parameter logic [BW-1:0]   NOP          = 'h13
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic [AW-1:0]              buyruk_adres_o,
    output logic                       istek_gecerli_o,
    input  logic [BW-1:0]              buyruk_i,
    input  logic                       buyruk_hazir_i,
    input  logic [YON_SAYISI-1:0]      yon_gecerli_i,
    input  logic [YON_SAYISI*AW-1:0]   yon_adres_i,
    input  logic                       durdur_i,
    output logic                       gecerli_o,
    output logic [AW-1:0]              ps_o,
    output logic [BW-1:0]              buyruk_o,
    output logic [$clog2(DERINLIK):0]  doluluk_o
);

    localparam int PW = $clog2(DERINLIK);
    localparam int CW = PW + 1;

    typedef enum logic {BOS, BEKLE} durum_t;

    typedef struct packed {
        logic [AW-1:0] ps;
        logic [BW-1:0] buyruk;
    } giris_t;

    durum_t          durum;
    logic            iptal;
    logic [AW-1:0]   ps_r;
    logic [PW-1:0]   yaz_ptr;
    logic [PW-1:0]   oku_ptr;
    logic [CW-1:0]   doluluk;
    giris_t          bellek [DERINLIK];

    logic            yon_aktif;
    logic [AW-1:0]   yon_hedef;
    logic            bekliyor;
    logic [CW:0]     kredi;
    logic            push;
    logic            pop;

    // Lowest-index asserted channel wins: scan downwards so it is assigned last.
    always_comb begin
        yon_aktif = 1'b0;
        yon_hedef = '0;
        for (int k = YON_SAYISI - 1; k >= 0; k--) begin
            if (yon_gecerli_i[k]) begin
                yon_aktif = 1'b1;
                yon_hedef = yon_adres_i[k*AW +: AW];
            end
        end
    end

    assign bekliyor = (durum == BEKLE);
    assign kredi    = (CW+1)'(doluluk) + (CW+1)'(bekliyor);
    assign push     = bekliyor && buyruk_hazir_i && !iptal && !yon_aktif;
    assign pop      = !yon_aktif && !durdur_i && (doluluk != '0);

    assign buyruk_adres_o = ps_r;
    assign doluluk_o      = doluluk;

    // Request FSM and fetch PC.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum           <= BOS;
            iptal           <= 1'b0;
            ps_r            <= BASLANGIC_PS;
            istek_gecerli_o <= 1'b0;
        end else begin
            case (durum)
                BOS: begin
                    if (!yon_aktif && kredi < (CW+1)'(DERINLIK)) begin
                        durum           <= BEKLE;
                        istek_gecerli_o <= 1'b1;
                    end
                end
                BEKLE: begin
                    if (buyruk_hazir_i) begin
                        durum           <= BOS;
                        istek_gecerli_o <= 1'b0;
                        iptal           <= 1'b0;
                    end else if (yon_aktif) begin
                        // Request already in flight for the old path: drop its answer.
                        iptal <= 1'b1;
                    end
                end
                default: begin
                    durum           <= BOS;
                    istek_gecerli_o <= 1'b0;
                end
            endcase

            if (yon_aktif)
                ps_r <= yon_hedef;
            else if (push)
                ps_r <= ps_r + AW'(4);
        end
    end

    // FIFO pointers, occupancy and output stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            yaz_ptr   <= '0;
            oku_ptr   <= '0;
            doluluk   <= '0;
            gecerli_o <= 1'b0;
            buyruk_o  <= NOP;
            ps_o      <= '0;
        end else if (yon_aktif) begin
            yaz_ptr   <= '0;
            oku_ptr   <= '0;
            doluluk   <= '0;
            gecerli_o <= 1'b0;
            buyruk_o  <= NOP;
        end else begin
            if (push)
                yaz_ptr <= yaz_ptr + PW'(1);
            if (pop)
                oku_ptr <= oku_ptr + PW'(1);
            doluluk <= doluluk + CW'(push) - CW'(pop);

            if (!durdur_i) begin
                if (doluluk == '0) begin
                    gecerli_o <= 1'b0;
                    buyruk_o  <= NOP;
                end else begin
                    gecerli_o <= 1'b1;
                    ps_o      <= bellek[oku_ptr].ps;
                    buyruk_o  <= bellek[oku_ptr].buyruk;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            bellek[yaz_ptr] <= '{ps: ps_r, buyruk: buyruk_i};
    end

endmodule

// File: tb/tb_getir_tamponu.sv
// Scoreboard bench for getir_tamponu: stimulus queues expected PCs, a negedge
// monitor checks every instruction decode consumes.
module tb_getir_tamponu;

    localparam int AW = 32;
    localparam int BW = 32;
    localparam int D  = 4;
    localparam int YS = 3;
    localparam int CW = $clog2(D) + 1;
    localparam logic [BW-1:0] NOP = 32'h0000_0013;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    logic [AW-1:0]    buyruk_adres_o;
    logic             istek_gecerli_o;
    logic [BW-1:0]    buyruk_i = '0;
    logic             buyruk_hazir_i = 1'b0;
    logic [YS-1:0]    yon_gecerli_i = '0;
    logic [YS*AW-1:0] yon_adres_i = '0;
    logic             durdur_i = 1'b1;
    logic             gecerli_o;
    logic [AW-1:0]    ps_o;
    logic [BW-1:0]    buyruk_o;
    logic [CW-1:0]    doluluk_o;

    getir_tamponu #(.DERINLIK(D), .AW(AW), .BW(BW), .YON_SAYISI(YS),
                    .BASLANGIC_PS(32'h0000_0000), .NOP(NOP)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .buyruk_adres_o(buyruk_adres_o), .istek_gecerli_o(istek_gecerli_o),
        .buyruk_i(buyruk_i), .buyruk_hazir_i(buyruk_hazir_i),
        .yon_gecerli_i(yon_gecerli_i), .yon_adres_i(yon_adres_i),
        .durdur_i(durdur_i), .gecerli_o(gecerli_o), .ps_o(ps_o),
        .buyruk_o(buyruk_o), .doluluk_o(doluluk_o)
    );

    // Second instance: start PC near the top of the address space, ideal cache.
    logic [AW-1:0] s_adres;
    logic          s_istek;
    logic          s_gecerli;
    logic [AW-1:0] s_ps;
    logic [BW-1:0] s_buyruk;
    logic [CW-1:0] s_doluluk;

    getir_tamponu #(.DERINLIK(D), .AW(AW), .BW(BW), .YON_SAYISI(YS),
                    .BASLANGIC_PS(32'hFFFF_FFF8), .NOP(NOP)) u_sar (
        .clk_i(clk_i), .rst_i(rst_i),
        .buyruk_adres_o(s_adres), .istek_gecerli_o(s_istek),
        .buyruk_i(s_adres), .buyruk_hazir_i(s_istek),
        .yon_gecerli_i(3'b000), .yon_adres_i(96'h0),
        .durdur_i(1'b0), .gecerli_o(s_gecerli), .ps_o(s_ps),
        .buyruk_o(s_buyruk), .doluluk_o(s_doluluk)
    );

    int karsilastirma = 0;
    int hata = 0;
    logic [AW-1:0] bq[$];
    logic [AW-1:0] mon_e;

    function automatic void kontrol(string ad, logic [31:0] gercek, logic [31:0] beklenen);
        karsilastirma++;
        if (gercek !== beklenen) begin
            hata++;
            $display("FAIL %s: got %h, expected %h", ad, gercek, beklenen);
        end
    endfunction

    // Cache model: answers cache_gecikme cycles after seeing a request, with
    // data equal to the address latched when the request first appeared.
    int            cache_gecikme = 0;
    int            c_say = 0;
    logic [AW-1:0] c_adres = '0;
    always @(posedge clk_i) begin
        #1;
        buyruk_hazir_i = 1'b0;
        if (istek_gecerli_o && !rst_i) begin
            if (c_say == 0) c_adres = buyruk_adres_o;
            if (c_say >= cache_gecikme) begin
                buyruk_hazir_i = 1'b1;
                buyruk_i       = c_adres;
                c_say          = 0;
            end else begin
                c_say++;
            end
        end else begin
            c_say = 0;
        end
    end

    // Decode consumes whatever is valid at an edge with no stall and no redirect.
    always @(negedge clk_i) begin
        if (!rst_i && gecerli_o && !durdur_i && yon_gecerli_i == '0) begin
            if (bq.size() == 0) begin
                karsilastirma++;
                hata++;
                $display("FAIL unexpected_output: got ps=%h, expected none", ps_o);
            end else begin
                mon_e = bq.pop_front();
                kontrol("cikis_ps", ps_o, mon_e);
                kontrol("cikis_buyruk", buyruk_o, mon_e);
            end
        end
    end

    logic [AW-1:0] sar_bek [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    int sar_i = 0;
    always @(negedge clk_i) begin
        if (!rst_i && s_gecerli && sar_i < 4) begin
            kontrol("sarma_ps", s_ps, sar_bek[sar_i]);
            kontrol("sarma_buyruk", s_buyruk, sar_bek[sar_i]);
            sar_i++;
        end
    end

    task automatic cevrim(int n);
        repeat (n) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    task automatic it(logic [AW-1:0] bas, int n);
        for (int i = 0; i < n; i++) bq.push_back(bas + AW'(4 * i));
    endtask

    // Release the stall until every expected instruction is consumed, then stall again.
    task automatic bosalt(string ad);
        int s;
        s = 0;
        durdur_i = 1'b0;
        while (bq.size() != 0 && s < 300) begin
            cevrim(1);
            s++;
        end
        durdur_i = 1'b1;
        kontrol(ad, bq.size(), 0);
        bq.delete();
    endtask

    task automatic yonlendir(logic [YS-1:0] v, logic [AW-1:0] a0, logic [AW-1:0] a1, logic [AW-1:0] a2);
        yon_adres_i   = {a2, a1, a0};
        yon_gecerli_i = v;
        cevrim(1);
        yon_gecerli_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        logic [AW-1:0] t_ps;
        logic [BW-1:0] t_b;
        logic          t_g;

        // Reset state
        cevrim(2);
        kontrol("rst_istek", 32'(istek_gecerli_o), 0);
        kontrol("rst_gecerli", 32'(gecerli_o), 0);
        kontrol("rst_buyruk", buyruk_o, NOP);
        kontrol("rst_ps", ps_o, 0);
        kontrol("rst_doluluk", 32'(doluluk_o), 0);
        kontrol("rst_adres", buyruk_adres_o, 0);
        rst_i = 1'b0;

        // Streaming fetch from 0
        cevrim(1);
        kontrol("ilk_istek", 32'(istek_gecerli_o), 1);
        kontrol("ilk_adres", buyruk_adres_o, 0);
        kontrol("ilk_nop", buyruk_o, NOP);
        it(32'h0, 8);
        bosalt("akis_bosalt");

        // Long stall: FIFO saturates, requests stop, output frozen
        t_ps = ps_o; t_b = buyruk_o; t_g = gecerli_o;
        cevrim(20);
        kontrol("durdur_doluluk", 32'(doluluk_o), 4);
        kontrol("durdur_istek", 32'(istek_gecerli_o), 0);
        kontrol("durdur_ps", ps_o, t_ps);
        kontrol("durdur_buyruk", buyruk_o, t_b);
        kontrol("durdur_gecerli", 32'(t_g), 32'(gecerli_o));
        it(32'h20, 6);
        durdur_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cevrim(1);
            kontrol("ardisik_pop", 32'(gecerli_o), 1);
        end
        bosalt("durdur_bosalt");

        // Two channels at once: channel 1 wins
        yonlendir(3'b110, 32'h0, 32'h100, 32'h200);
        kontrol("yon_adres", buyruk_adres_o, 32'h100);
        kontrol("yon_doluluk", 32'(doluluk_o), 0);
        kontrol("yon_gecerli", 32'(gecerli_o), 0);
        kontrol("yon_nop", buyruk_o, NOP);
        it(32'h100, 3);
        durdur_i = 1'b0;
        cevrim(1);
        kontrol("yon_gecikme1", 32'(gecerli_o), 0);
        cevrim(1);
        kontrol("yon_gecikme2", 32'(gecerli_o), 0);
        bosalt("yon_bosalt");

        // Redirect while a request is in flight; its answer must be dropped
        cache_gecikme = 2;
        cevrim(12);
        yonlendir(3'b001, 32'h300, 32'h0, 32'h0);
        s = 0;
        while (!istek_gecerli_o && s < 20) begin cevrim(1); s++; end
        kontrol("iptal_istek", 32'(istek_gecerli_o), 1);
        kontrol("iptal_eski_adres", buyruk_adres_o, 32'h300);
        yonlendir(3'b001, 32'h400, 32'h0, 32'h0);
        kontrol("iptal_yeni_adres", buyruk_adres_o, 32'h400);
        kontrol("iptal_bekle", 32'(istek_gecerli_o), 1);
        s = 0;
        while (istek_gecerli_o && s < 20) begin cevrim(1); s++; end
        kontrol("iptal_dusus", 32'(istek_gecerli_o), 0);
        kontrol("iptal_doluluk", 32'(doluluk_o), 0);
        s = 0;
        while (!istek_gecerli_o && s < 20) begin cevrim(1); s++; end
        kontrol("iptal_sonraki_adres", buyruk_adres_o, 32'h400);
        it(32'h400, 2);
        bosalt("iptal_bosalt");

        // Redirect in the same cycle as a response, while stalled
        s = 0;
        while (doluluk_o != 3 && s < 60) begin cevrim(1); s++; end
        kontrol("ayni_dolu", 32'(doluluk_o), 3);
        s = 0;
        while (!buyruk_hazir_i && s < 20) begin cevrim(1); s++; end
        kontrol("ayni_hazir", 32'(buyruk_hazir_i), 1);
        yonlendir(3'b100, 32'h0, 32'h0, 32'h600);
        kontrol("ayni_gecerli", 32'(gecerli_o), 0);
        kontrol("ayni_nop", buyruk_o, NOP);
        kontrol("ayni_doluluk", 32'(doluluk_o), 0);
        kontrol("ayni_istek", 32'(istek_gecerli_o), 0);
        kontrol("ayni_adres", buyruk_adres_o, 32'h600);
        it(32'h600, 2);
        bosalt("ayni_bosalt");

        kontrol("sarma_sayi", sar_i, 4);

        // Reset beats a simultaneous response and redirect
        s = 0;
        while (!buyruk_hazir_i && s < 40) begin cevrim(1); s++; end
        yon_adres_i   = {32'h0, 32'h700, 32'h0};
        yon_gecerli_i = 3'b010;
        rst_i         = 1'b1;
        cevrim(1);
        yon_gecerli_i = '0;
        kontrol("rst2_istek", 32'(istek_gecerli_o), 0);
        kontrol("rst2_adres", buyruk_adres_o, 0);
        kontrol("rst2_gecerli", 32'(gecerli_o), 0);
        kontrol("rst2_ps", ps_o, 0);
        kontrol("rst2_buyruk", buyruk_o, NOP);
        kontrol("rst2_doluluk", 32'(doluluk_o), 0);
        rst_i = 1'b0;
        cevrim(1);
        kontrol("kuyruk_bos", bq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", karsilastirma, hata);
        $finish;
    end

endmodule

// File: doc/getir_tamponu.md
Name: getir_tamponu

Overview:
- Parametrised fetch front-end: generates the fetch PC, issues one outstanding request at a time to the instruction cache and buffers returned {ps, buyruk} pairs in a DERINLIK-entry FIFO.
- Feeds the decode stage through a registered output stage.
- Generalises the single-entry stall buffer to a FIFO of configurable depth, and the fixed redirect inputs to YON_SAYISI prioritised redirect channels.

Parameters:
- DERINLIK, 4, FIFO entries; power of two, at least 2.
- AW, 32, address width.
- BW, 32, instruction width.
- YON_SAYISI, 3, number of redirect channels; channel 0 has highest priority.
- BASLANGIC_PS, 32'h0000_0000, PC value after reset.
- NOP, 32'h0000_0013, instruction driven on the output when no valid instruction is present.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- buyruk_adres_o  out  AW  fetch address to the cache.
- istek_gecerli_o  out  1  request valid; the address is held stable while this is high and no response has arrived.
- buyruk_i  in  BW  cache data.
- buyruk_hazir_i  in  1  one-cycle response strobe for the current request.
- yon_gecerli_i  in  YON_SAYISI  per-channel redirect valid.
- yon_adres_i  in  YON_SAYISI*AW  per-channel target; channel k occupies bits [k*AW +: AW].
- durdur_i  in  1  decode stall.
- gecerli_o  out  1  output holds a valid instruction.
- ps_o  out  AW  PC of buyruk_o.
- buyruk_o  out  BW  instruction to decode.
- doluluk_o  out  $clog2(DERINLIK)+1  number of occupied FIFO entries.

Behaviour:
Reset (rst_i=1 at a clock edge):
- ps_r=BASLANGIC_PS, FIFO empty, doluluk_o=0.
- istek_gecerli_o=0, gecerli_o=0, buyruk_o=NOP, ps_o=0.
- Internal flags bekliyor=0, iptal=0.
- Reset overrides every other input in the same cycle, including a mid-operation response or redirect.

Request FSM, states BOS / BEKLE:
- BOS -> BEKLE when (doluluk + bekliyor) < DERINLIK and no redirect is active this cycle. istek_gecerli_o=1 in BEKLE.
- BEKLE, buyruk_hazir_i=1, iptal=0:
  - push {ps_r, buyruk_i} into the FIFO;
  - ps_r += 4 (modulo 2^AW, wraps silently);
  - go to BOS.
- BEKLE, buyruk_hazir_i=1, iptal=1: discard the data, clear iptal, go to BOS.
- buyruk_adres_o = ps_r at all times.
- Minimum request-to-request spacing: 1 idle cycle (BOS) between requests.

Redirect (any bit of yon_gecerli_i high):
- Select the lowest-index asserted channel k. At the clock edge:
  - ps_r = yon_adres_i[k];
  - FIFO flushed, doluluk_o=0;
  - output stage set to gecerli_o=0, buyruk_o=NOP.
- If in BEKLE with no response this cycle: iptal=1, stay in BEKLE, and drop the next response.
- If a response arrives in the same cycle: the response is dropped, the FSM goes to BOS and iptal stays 0.
- Redirect takes priority over durdur_i: it flushes even while stalled.
- The first instruction from the new target appears at the output no earlier than 3 cycles after the redirect edge.

Output stage (evaluated only when no redirect is active):
- durdur_i=1: hold ps_o, buyruk_o and gecerli_o unchanged.
- durdur_i=0, FIFO non-empty: pop the head into ps_o/buyruk_o and set gecerli_o=1.
- durdur_i=0, FIFO empty: gecerli_o=0 and buyruk_o=NOP; ps_o holds its value.
- A push and a pop in the same cycle leave doluluk unchanged.
- A push is allowed into an empty FIFO, with the pop on the following cycle; there is no bypass.

FIFO:
- Circular buffer with read/write pointers of $clog2(DERINLIK) bits that wrap modulo DERINLIK.
- Full is prevented by the credit rule (doluluk + bekliyor ≤ DERINLIK), so overflow is impossible.
- A response while full is a protocol error and is not required to be handled.

Test Plan:
- Reset, then a cache responding 1 cycle after each request with instruction = address, durdur_i=0 -> addresses 0,4,8,...; output sequence (ps_o, buyruk_o) = (0,0), (4,4), ... with gecerli_o=1; buyruk_o=NOP before the first instruction.
- Hold durdur_i=1 for 20 cycles -> doluluk_o saturates at 4, istek_gecerli_o stays 0 with no more than DERINLIK pushes, output frozen; on release, 4 consecutive pops at PCs 8,C,10,14 with no loss.
- yon_gecerli_i=3'b110 with channel 1 target 0x100 and channel 2 target 0x200 -> buyruk_adres_o=0x100, FIFO flushed, gecerli_o=0 the next cycle, first output ps_o=0x100.
- Redirect while in BEKLE, with the stale response arriving 2 cycles later -> stale data not pushed, next request issued to the target address.
- Redirect in the same cycle as buyruk_hazir_i and durdur_i=1 -> response dropped, flush performed, outputs NOP with gecerli_o=0.
- BASLANGIC_PS=32'hFFFF_FFF8 -> PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap-around).
